rs_aged: RTL and testbench

RS_AGED -- requirements
Module: rs_aged

---
 rtl/sys_defs.sv | 20 ++
 rtl/age_select.sv | 20 ++
 rtl/rs_aged.sv | 174 +++++++++++++++++
 tb/tb_rs_aged.sv | 379 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sys_defs.sv
// Shared reservation-station types: entry layout, branch-mask type and the empty entry.
package sys_defs;

  localparam int SYS_TAG_W   = 6;
  localparam int SYS_BMASK_W = 4;

  typedef logic [SYS_BMASK_W-1:0] BMASK_T;

  typedef struct packed {
    logic [SYS_TAG_W-1:0] dest;
    logic [SYS_TAG_W-1:0] t1;
    logic [SYS_TAG_W-1:0] t2;
    logic                 t1_ready;
    logic                 t2_ready;
    BMASK_T               bmask;
  } RS_ENTRY_T;

  localparam RS_ENTRY_T EMPTY_ENTRY = '0;

endpackage

// File: rtl/age_select.sv
// Oldest-requester picker: age[i][j] set means entry i is older than entry j.
module age_select #(
  parameter int DEPTH = 16
) (
  input  logic [DEPTH-1:0]            req,
  input  logic [DEPTH-1:0][DEPTH-1:0] age,
  output logic [DEPTH-1:0]            grant
);

  always_comb begin
    grant = '0;
    for (int i = 0; i < DEPTH; i++) begin
      grant[i] = req[i];
      for (int j = 0; j < DEPTH; j++) begin
        if (j != i && req[j] && age[j][i]) grant[i] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/rs_aged.sv
// Reservation station with CDB wakeup, branch-mask squash/resolve and
// oldest-first multi-port issue driven by an allocation-time age matrix.
module rs_aged
  import sys_defs::*;
#(
  parameter int DEPTH   = 16,
  parameter int DISP_W  = 2,
  parameter int ISSUE_W = 2,
  parameter int CDB_W   = 2,
  parameter int TAG_W   = SYS_TAG_W,
  parameter int BMASK_W = SYS_BMASK_W,
  localparam int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [DISP_W-1:0]             disp_valid,
  input  RS_ENTRY_T [DISP_W-1:0]        disp_row,
  input  logic [CDB_W-1:0]              cdb_valid,
  input  logic [CDB_W-1:0][TAG_W-1:0]   cdb_tag,
  input  logic [ISSUE_W-1:0]            issue_stall,
  input  logic                          br_resolve_valid,
  input  logic [BMASK_W-1:0]            br_resolve_mask,
  input  logic                          br_squash_valid,
  input  logic [BMASK_W-1:0]            br_squash_mask,
  output logic [ISSUE_W-1:0]            issue_valid,
  output RS_ENTRY_T [ISSUE_W-1:0]       issue_row,
  output logic [CNT_W-1:0]              free_count,
  output logic                          full
);

  localparam int LANE_W = (DISP_W > 1) ? $clog2(DISP_W) : 1;

  logic [DEPTH-1:0]            busy, busy_n;
  RS_ENTRY_T [DEPTH-1:0]       entries, entries_n;
  logic [DEPTH-1:0][DEPTH-1:0] age, age_n;
  logic [CNT_W-1:0]            free_count_n;

  RS_ENTRY_T [DEPTH-1:0]       woken;
  logic [DEPTH-1:0]            squash_hit;
  logic [DEPTH-1:0]            ready;
  logic [DEPTH-1:0]            issued;
  logic [DEPTH-1:0]            alloc_new;
  logic [LANE_W-1:0]           alloc_lane [DEPTH];
  logic [DEPTH-1:0]            remaining [ISSUE_W+1];
  logic [DEPTH-1:0]            grant [ISSUE_W];

  function automatic logic cdb_hit(input logic [SYS_TAG_W-1:0]          tag,
                                   input logic [CDB_W-1:0]              v,
                                   input logic [CDB_W-1:0][TAG_W-1:0]   tags);
    logic hit;
    hit = 1'b0;
    for (int c = 0; c < CDB_W; c++) begin
      if (v[c] && tags[c] == tag) hit = 1'b1;
    end
    return hit;
  endfunction

  // Current entries with this cycle's broadcasts folded in; squashed entries never request.
  always_comb begin
    woken      = entries;
    squash_hit = '0;
    ready      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      woken[i].t1_ready = entries[i].t1_ready | cdb_hit(entries[i].t1, cdb_valid, cdb_tag);
      woken[i].t2_ready = entries[i].t2_ready | cdb_hit(entries[i].t2, cdb_valid, cdb_tag);
      squash_hit[i]     = br_squash_valid && |(entries[i].bmask & br_squash_mask);
      ready[i]          = busy[i] && woken[i].t1_ready && woken[i].t2_ready && !squash_hit[i];
    end
  end

  assign remaining[0] = ready;

  for (genvar p = 0; p < ISSUE_W; p++) begin : g_port
    age_select #(.DEPTH(DEPTH)) u_age_select (
      .req   (remaining[p]),
      .age   (age),
      .grant (grant[p])
    );
    assign remaining[p+1] = issue_stall[p] ? remaining[p] : (remaining[p] & ~grant[p]);
  end

  always_comb begin
    issue_valid = '0;
    issue_row   = '0;
    issued      = '0;
    for (int p = 0; p < ISSUE_W; p++) begin
      if (!issue_stall[p] && |grant[p]) begin
        issue_valid[p] = 1'b1;
        issued         = issued | grant[p];
        for (int i = 0; i < DEPTH; i++) begin
          if (grant[p][i]) issue_row[p] = woken[i];
        end
      end
    end
  end

  // Lanes are accepted in order against the registered free count, then packed into the lowest free slots.
  always_comb begin
    logic [CNT_W-1:0] accepted;
    logic [DEPTH-1:0] taken;
    logic             found;
    accepted  = '0;
    taken     = busy;
    found     = 1'b0;
    alloc_new = '0;
    for (int i = 0; i < DEPTH; i++) alloc_lane[i] = '0;
    for (int k = 0; k < DISP_W; k++) begin
      if (disp_valid[k] && accepted < free_count) begin
        accepted = accepted + 1'b1;
        if (!(br_squash_valid && |(disp_row[k].bmask & br_squash_mask))) begin
          found = 1'b0;
          for (int i = 0; i < DEPTH; i++) begin
            if (!found && !taken[i]) begin
              found         = 1'b1;
              taken[i]      = 1'b1;
              alloc_new[i]  = 1'b1;
              alloc_lane[i] = LANE_W'(k);
            end
          end
        end
      end
    end
  end

  always_comb begin
    logic [CNT_W-1:0] busy_cnt;
    busy_n    = busy;
    entries_n = entries;
    age_n     = age;
    busy_cnt  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (alloc_new[i]) begin
        busy_n[i]             = 1'b1;
        entries_n[i]          = disp_row[alloc_lane[i]];
        entries_n[i].t1_ready = disp_row[alloc_lane[i]].t1_ready
                                | cdb_hit(disp_row[alloc_lane[i]].t1, cdb_valid, cdb_tag);
        entries_n[i].t2_ready = disp_row[alloc_lane[i]].t2_ready
                                | cdb_hit(disp_row[alloc_lane[i]].t2, cdb_valid, cdb_tag);
      end else begin
        busy_n[i]             = busy[i] & ~issued[i] & ~squash_hit[i];
        entries_n[i].t1_ready = woken[i].t1_ready;
        entries_n[i].t2_ready = woken[i].t2_ready;
      end
      if (br_resolve_valid) entries_n[i].bmask = entries_n[i].bmask & ~br_resolve_mask;
      busy_cnt = busy_cnt + CNT_W'(busy_n[i]);
    end
    // A new entry is younger than everything already held and than lower-lane siblings.
    for (int x = 0; x < DEPTH; x++) begin
      for (int y = 0; y < DEPTH; y++) begin
        if (x == y)            age_n[x][y] = 1'b0;
        else if (alloc_new[x]) age_n[x][y] = alloc_new[y] && (alloc_lane[y] > alloc_lane[x]);
        else if (alloc_new[y]) age_n[x][y] = 1'b1;
      end
    end
    free_count_n = CNT_W'(DEPTH) - busy_cnt;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      busy       <= '0;
      age        <= '0;
      free_count <= CNT_W'(DEPTH);
      for (int i = 0; i < DEPTH; i++) entries[i] <= EMPTY_ENTRY;
    end else begin
      busy       <= busy_n;
      entries    <= entries_n;
      age        <= age_n;
      free_count <= free_count_n;
    end
  end

  assign full = (free_count == '0);

endmodule

// File: tb/tb_rs_aged.sv
// Self-checking bench for rs_aged: directed scenarios plus a randomized run
// against an age-ordered queue model of the station.
module tb_rs_aged;
  import sys_defs::*;

  localparam int DEPTH   = 16;
  localparam int DISP_W  = 2;
  localparam int ISSUE_W = 2;
  localparam int CDB_W   = 2;
  localparam int TAG_W   = 6;
  localparam int BMASK_W = 4;
  localparam int CNT_W   = 5;

  logic                        clock = 1'b0;
  logic                        reset = 1'b1;
  logic [DISP_W-1:0]           disp_valid;
  RS_ENTRY_T [DISP_W-1:0]      disp_row;
  logic [CDB_W-1:0]            cdb_valid;
  logic [CDB_W-1:0][TAG_W-1:0] cdb_tag;
  logic [ISSUE_W-1:0]          issue_stall;
  logic                        br_resolve_valid;
  logic [BMASK_W-1:0]          br_resolve_mask;
  logic                        br_squash_valid;
  logic [BMASK_W-1:0]          br_squash_mask;
  logic [ISSUE_W-1:0]          issue_valid;
  RS_ENTRY_T [ISSUE_W-1:0]     issue_row;
  logic [CNT_W-1:0]            free_count;
  logic                        full;

  int checks = 0;
  int fails  = 0;
  int dest_ctr = 0;

  always #5 clock = ~clock;

  rs_aged #(
    .DEPTH(DEPTH), .DISP_W(DISP_W), .ISSUE_W(ISSUE_W), .CDB_W(CDB_W),
    .TAG_W(TAG_W), .BMASK_W(BMASK_W)
  ) dut (
    .clock(clock), .reset(reset),
    .disp_valid(disp_valid), .disp_row(disp_row),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
    .issue_stall(issue_stall),
    .br_resolve_valid(br_resolve_valid), .br_resolve_mask(br_resolve_mask),
    .br_squash_valid(br_squash_valid), .br_squash_mask(br_squash_mask),
    .issue_valid(issue_valid), .issue_row(issue_row),
    .free_count(free_count), .full(full)
  );

  function automatic RS_ENTRY_T mk_row(input int dest, input int t1, input int t2,
                                       input bit r1, input bit r2, input int bm);
    RS_ENTRY_T r;
    r.dest     = TAG_W'(dest);
    r.t1       = TAG_W'(t1);
    r.t2       = TAG_W'(t2);
    r.t1_ready = r1;
    r.t2_ready = r2;
    r.bmask    = BMASK_W'(bm);
    return r;
  endfunction

  function automatic bit tb_hit(input logic [TAG_W-1:0] tag);
    for (int c = 0; c < CDB_W; c++) if (cdb_valid[c] && cdb_tag[c] == tag) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit tb_squashed(input logic [BMASK_W-1:0] bm);
    return br_squash_valid && ((bm & br_squash_mask) != '0);
  endfunction

  task automatic clear_inputs();
    disp_valid       = '0;
    disp_row         = '0;
    cdb_valid        = '0;
    cdb_tag          = '0;
    issue_stall      = '0;
    br_resolve_valid = 1'b0;
    br_resolve_mask  = '0;
    br_squash_valid  = 1'b0;
    br_squash_mask   = '0;
  endtask

  task automatic cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b0;
    cycle();
    cycle();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b1;
    #1;
    reset = 1'b0;
    #2;
    checks++; if (free_count !== CNT_W'(16)) begin fails++; $display("[TB] FAIL reset_free_count: got %0d expected 16", free_count); end
    checks++; if (full !== 1'b0) begin fails++; $display("[TB] FAIL reset_full: got %0b expected 0", full); end
    checks++; if (issue_valid !== 2'b00) begin fails++; $display("[TB] FAIL reset_issue_valid: got %b expected 00", issue_valid); end
    cycle();
    reset = 1'b1;
    #2;
    checks++; if (free_count !== CNT_W'(16)) begin fails++; $display("[TB] FAIL post_reset_free_count: got %0d expected 16", free_count); end
  endtask

  task automatic test_age_order();
    do_reset();
    issue_stall = 2'b10;
    disp_valid = 2'b01; disp_row[0] = mk_row(1, 0, 0, 1, 1, 0);
    #2;
    checks++; if (issue_valid !== 2'b00) begin fails++; $display("[TB] FAIL age_c1_valid: got %b expected 00", issue_valid); end
    cycle();
    disp_row[0] = mk_row(2, 5, 0, 0, 1, 0);
    #2;
    checks++; if (issue_valid !== 2'b01 || issue_row[0] !== mk_row(1, 0, 0, 1, 1, 0)) begin
      fails++; $display("[TB] FAIL age_filler_issue: got valid %b row %h expected 01 row %h", issue_valid, issue_row[0], mk_row(1, 0, 0, 1, 1, 0)); end
    cycle();
    disp_row[0] = mk_row(3, 5, 0, 0, 1, 0);
    #2;
    checks++; if (issue_valid !== 2'b00) begin fails++; $display("[TB] FAIL age_c3_valid: got %b expected 00", issue_valid); end
    cycle();
    disp_valid = '0; cdb_valid = 2'b01; cdb_tag[0] = TAG_W'(5);
    #2;
    checks++; if (issue_valid !== 2'b01 || issue_row[0] !== mk_row(2, 5, 0, 1, 1, 0)) begin
      fails++; $display("[TB] FAIL age_a_first: got valid %b row %h expected 01 row %h", issue_valid, issue_row[0], mk_row(2, 5, 0, 1, 1, 0)); end
    cycle();
    cdb_valid = '0;
    #2;
    checks++; if (issue_valid !== 2'b01 || issue_row[0] !== mk_row(3, 5, 0, 1, 1, 0)) begin
      fails++; $display("[TB] FAIL age_b_second: got valid %b row %h expected 01 row %h", issue_valid, issue_row[0], mk_row(3, 5, 0, 1, 1, 0)); end
    cycle();
    #2;
    checks++; if (free_count !== CNT_W'(16)) begin fails++; $display("[TB] FAIL age_drained: got %0d expected 16", free_count); end
  endtask

  task automatic test_dispatch_bypass();
    do_reset();
    disp_valid  = 2'b11;
    disp_row[0] = mk_row(4, 9, 3, 0, 1, 0);
    disp_row[1] = mk_row(5, 30, 9, 1, 0, 0);
    cdb_valid   = 2'b01; cdb_tag[0] = TAG_W'(9);
    #2;
    checks++; if (issue_valid !== 2'b00) begin fails++; $display("[TB] FAIL bypass_same_cycle: got %b expected 00", issue_valid); end
    cycle();
    clear_inputs();
    #2;
    checks++; if (issue_valid !== 2'b11) begin fails++; $display("[TB] FAIL bypass_valid: got %b expected 11", issue_valid); end
    checks++; if (issue_row[0] !== mk_row(4, 9, 3, 1, 1, 0)) begin fails++; $display("[TB] FAIL bypass_row0: got %h expected %h", issue_row[0], mk_row(4, 9, 3, 1, 1, 0)); end
    checks++; if (issue_row[1] !== mk_row(5, 30, 9, 1, 1, 0)) begin fails++; $display("[TB] FAIL bypass_row1: got %h expected %h", issue_row[1], mk_row(5, 30, 9, 1, 1, 0)); end
    cycle();
    #2;
    checks++; if (free_count !== CNT_W'(16)) begin fails++; $display("[TB] FAIL bypass_freed: got %0d expected 16", free_count); end
  endtask

  task automatic test_selective_squash();
    do_reset();
    issue_stall = 2'b11;
    disp_valid  = 2'b11;
    disp_row[0] = mk_row(10, 20, 20, 0, 0, 4'b0001);
    disp_row[1] = mk_row(11, 20, 20, 0, 0, 4'b0010);
    cycle();
    disp_valid  = 2'b01;
    disp_row[0] = mk_row(12, 20, 20, 0, 0, 4'b0000);
    cycle();
    disp_valid = '0;
    #2;
    checks++; if (free_count !== CNT_W'(13)) begin fails++; $display("[TB] FAIL squash_before: got %0d expected 13", free_count); end
    br_squash_valid = 1'b1; br_squash_mask = 4'b0001;
    cycle();
    br_squash_valid = 1'b0;
    #2;
    checks++; if (free_count !== CNT_W'(14)) begin fails++; $display("[TB] FAIL squash_after: got %0d expected 14", free_count); end
    br_resolve_valid = 1'b1; br_resolve_mask = 4'b0010;
    cycle();
    br_resolve_valid = 1'b0;
    br_squash_valid = 1'b1; br_squash_mask = 4'b0010;
    cycle();
    br_squash_valid = 1'b0;
    #2;
    checks++; if (free_count !== CNT_W'(14)) begin fails++; $display("[TB] FAIL resolve_protects: got %0d expected 14", free_count); end
    issue_stall = 2'b00; cdb_valid = 2'b10; cdb_tag[1] = TAG_W'(20);
    #2;
    checks++; if (issue_valid !== 2'b11 || issue_row[0] !== mk_row(11, 20, 20, 1, 1, 0) || issue_row[1] !== mk_row(12, 20, 20, 1, 1, 0)) begin
      fails++; $display("[TB] FAIL squash_survivors: got valid %b rows %h %h expected 11 rows %h %h", issue_valid, issue_row[0], issue_row[1],
                        mk_row(11, 20, 20, 1, 1, 0), mk_row(12, 20, 20, 1, 1, 0)); end
    cycle();
  endtask

  task automatic test_stall_shift();
    do_reset();
    issue_stall = 2'b11;
    disp_valid  = 2'b11;
    disp_row[0] = mk_row(20, 1, 2, 1, 1, 0);
    disp_row[1] = mk_row(21, 1, 2, 1, 1, 0);
    cycle();
    disp_valid  = '0;
    issue_stall = 2'b01;
    #2;
    checks++; if (issue_valid !== 2'b10 || issue_row[1] !== mk_row(20, 1, 2, 1, 1, 0)) begin
      fails++; $display("[TB] FAIL stall_shift_port1: got valid %b row %h expected 10 row %h", issue_valid, issue_row[1], mk_row(20, 1, 2, 1, 1, 0)); end
    cycle();
    issue_stall = 2'b11;
    #2;
    checks++; if (issue_valid !== 2'b00) begin fails++; $display("[TB] FAIL stall_all_idle: got %b expected 00", issue_valid); end
    checks++; if (free_count !== CNT_W'(15)) begin fails++; $display("[TB] FAIL stall_remaining: got %0d expected 15", free_count); end
    issue_stall = 2'b00;
    #2;
    checks++; if (issue_valid !== 2'b01 || issue_row[0] !== mk_row(21, 1, 2, 1, 1, 0)) begin
      fails++; $display("[TB] FAIL stall_other_entry: got valid %b row %h expected 01 row %h", issue_valid, issue_row[0], mk_row(21, 1, 2, 1, 1, 0)); end
    cycle();
  endtask

  task automatic test_fill();
    int exp_q[$];
    do_reset();
    issue_stall = 2'b11;
    for (int c = 0; c < 8; c++) begin
      disp_valid  = 2'b11;
      disp_row[0] = mk_row(32 + 2 * c, 0, 0, 1, 1, 0);
      disp_row[1] = mk_row(33 + 2 * c, 0, 0, 1, 1, 0);
      cycle();
    end
    disp_valid = '0;
    #2;
    checks++; if (full !== 1'b1 || free_count !== CNT_W'(0)) begin fails++; $display("[TB] FAIL fill_full: got full %0b count %0d expected 1 0", full, free_count); end
    issue_stall = 2'b10;
    #2;
    checks++; if (issue_valid !== 2'b01 || issue_row[0].dest !== TAG_W'(32)) begin
      fails++; $display("[TB] FAIL fill_oldest: got valid %b dest %0d expected 01 dest 32", issue_valid, issue_row[0].dest); end
    cycle();
    issue_stall = 2'b11;
    #2;
    checks++; if (free_count !== CNT_W'(1) || full !== 1'b0) begin fails++; $display("[TB] FAIL fill_one_free: got count %0d full %0b expected 1 0", free_count, full); end
    disp_valid  = 2'b11;
    disp_row[0] = mk_row(50, 0, 0, 1, 1, 0);
    disp_row[1] = mk_row(51, 0, 0, 1, 1, 0);
    cycle();
    disp_valid = '0;
    #2;
    checks++; if (free_count !== CNT_W'(0) || full !== 1'b1) begin fails++; $display("[TB] FAIL fill_excess_dropped: got count %0d full %0b expected 0 1", free_count, full); end
    for (int d = 33; d <= 47; d++) exp_q.push_back(d);
    exp_q.push_back(50);
    issue_stall = 2'b00;
    for (int i = 0; i < 8; i++) begin
      #2;
      checks++; if (issue_valid !== 2'b11 || issue_row[0].dest !== TAG_W'(exp_q[2*i]) || issue_row[1].dest !== TAG_W'(exp_q[2*i+1])) begin
        fails++; $display("[TB] FAIL fill_drain_%0d: got valid %b dests %0d %0d expected 11 dests %0d %0d", i, issue_valid,
                          issue_row[0].dest, issue_row[1].dest, exp_q[2*i], exp_q[2*i+1]); end
      cycle();
    end
    #2;
    checks++; if (free_count !== CNT_W'(16)) begin fails++; $display("[TB] FAIL fill_drained: got %0d expected 16", free_count); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    issue_stall = 2'b11;
    disp_valid  = 2'b11;
    disp_row[0] = mk_row(60, 0, 0, 1, 1, 0);
    disp_row[1] = mk_row(61, 0, 0, 1, 1, 0);
    cycle();
    disp_valid  = '0;
    issue_stall = 2'b00;
    #2;
    checks++; if (issue_valid !== 2'b11) begin fails++; $display("[TB] FAIL mid_reset_before: got %b expected 11", issue_valid); end
    reset = 1'b0;
    #1;
    checks++; if (issue_valid !== 2'b00 || free_count !== CNT_W'(16) || full !== 1'b0) begin
      fails++; $display("[TB] FAIL mid_reset_discard: got valid %b count %0d full %0b expected 00 16 0", issue_valid, free_count, full); end
    cycle();
    reset = 1'b1;
    clear_inputs();
  endtask

  task automatic test_random();
    RS_ENTRY_T  q[$];
    RS_ENTRY_T  nq[$];
    RS_ENTRY_T  e;
    RS_ENTRY_T  exp_row;
    int         rdy_idx[$];
    bit         gone [DEPTH];
    bit         exp_v;
    int         nfree, used, acc, ptr;
    do_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      clear_inputs();
      nfree = DEPTH - q.size();
      used  = 0;
      for (int k = 0; k < DISP_W; k++) begin
        if (used < nfree && $urandom_range(0, 2) != 0) begin
          disp_valid[k] = 1'b1;
          used++;
          disp_row[k] = mk_row(dest_ctr % 64, $urandom_range(0, 15), $urandom_range(0, 15),
                               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                               ($urandom_range(0, 1) != 0) ? (1 << $urandom_range(0, 3)) : 0);
          dest_ctr++;
        end
      end
      for (int c = 0; c < CDB_W; c++) begin
        cdb_valid[c] = 1'($urandom_range(0, 1));
        cdb_tag[c]   = TAG_W'($urandom_range(0, 15));
      end
      issue_stall = ISSUE_W'($urandom_range(0, 3));
      if ($urandom_range(0, 5) == 0) begin br_resolve_valid = 1'b1; br_resolve_mask = BMASK_W'(1 << $urandom_range(0, 3)); end
      if ($urandom_range(0, 7) == 0) begin br_squash_valid = 1'b1; br_squash_mask = BMASK_W'(1 << $urandom_range(0, 3)); end
      #2;
      rdy_idx.delete();
      for (int i = 0; i < DEPTH; i++) gone[i] = 1'b0;
      for (int i = 0; i < q.size(); i++) begin
        if ((q[i].t1_ready || tb_hit(q[i].t1)) && (q[i].t2_ready || tb_hit(q[i].t2)) && !tb_squashed(q[i].bmask))
          rdy_idx.push_back(i);
      end
      ptr = 0;
      for (int p = 0; p < ISSUE_W; p++) begin
        exp_v   = 1'b0;
        exp_row = EMPTY_ENTRY;
        if (!issue_stall[p] && ptr < rdy_idx.size()) begin
          exp_v            = 1'b1;
          exp_row          = q[rdy_idx[ptr]];
          exp_row.t1_ready = 1'b1;
          exp_row.t2_ready = 1'b1;
          gone[rdy_idx[ptr]] = 1'b1;
          ptr++;
        end
        checks++; if (issue_valid[p] !== exp_v) begin fails++; $display("[TB] FAIL rand_valid c%0d p%0d: got %b expected %b", cyc, p, issue_valid[p], exp_v); end
        if (exp_v) begin
          checks++; if (issue_row[p] !== exp_row) begin fails++; $display("[TB] FAIL rand_row c%0d p%0d: got %h expected %h", cyc, p, issue_row[p], exp_row); end
        end
      end
      nq.delete();
      for (int i = 0; i < q.size(); i++) begin
        if (!gone[i] && !tb_squashed(q[i].bmask)) begin
          e = q[i];
          e.t1_ready = e.t1_ready | tb_hit(e.t1);
          e.t2_ready = e.t2_ready | tb_hit(e.t2);
          if (br_resolve_valid) e.bmask = e.bmask & ~br_resolve_mask;
          nq.push_back(e);
        end
      end
      acc = 0;
      for (int k = 0; k < DISP_W; k++) begin
        if (disp_valid[k] && acc < nfree) begin
          acc++;
          if (!tb_squashed(disp_row[k].bmask)) begin
            e = disp_row[k];
            e.t1_ready = e.t1_ready | tb_hit(e.t1);
            e.t2_ready = e.t2_ready | tb_hit(e.t2);
            if (br_resolve_valid) e.bmask = e.bmask & ~br_resolve_mask;
            nq.push_back(e);
          end
        end
      end
      q = nq;
      cycle();
      checks++; if (free_count !== CNT_W'(DEPTH - q.size())) begin fails++; $display("[TB] FAIL rand_free c%0d: got %0d expected %0d", cyc, free_count, DEPTH - q.size()); end
      checks++; if (full !== (q.size() == DEPTH)) begin fails++; $display("[TB] FAIL rand_full c%0d: got %0b expected %0b", cyc, full, q.size() == DEPTH); end
    end
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_age_order();
    test_dispatch_bypass();
    test_selective_squash();
    test_stall_shift();
    test_fill();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
